// File: rtl/alu_pkg.sv
// Shared ALU operation codes plus the muldiv sequencer's operation and state types.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Radix-2 unsigned multiply/divide sequencer that borrows the shared ALU for every add/subtract.
// hi/lo double as remainder/quotient during division.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [DATA_WIDTH-1:0]    operand_a,
    input  logic [DATA_WIDTH-1:0]    operand_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     alu_req,
    input  logic                     alu_gnt,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam logic [5:0] LAST_CNT = 6'(DATA_WIDTH - 1);

    seq_state_t            state_r, state_s;
    muldiv_op_t            op_r, op_s;
    logic [DATA_WIDTH-1:0] hi_r, hi_s;
    logic [DATA_WIDTH-1:0] lo_r, lo_s;
    logic [DATA_WIDTH-1:0] opnd_r, opnd_s;
    logic [5:0]            cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;
    logic [DATA_WIDTH-1:0] sh_s;
    logic                  carry_s;
    logic                  ge_s;
    logic                  is_div_s;

    assign is_div_s = op_r[1];
    assign busy     = (state_r == RUN);
    assign alu_req  = (state_r == RUN);
    assign done     = (state_r == DONE);
    assign result   = result_r;

    // ALU operand steering; outputs rest at zero/AND outside RUN
    always_comb begin
        alu_src_a     = '0;
        alu_src_b     = '0;
        alu_operation = '0;
        sh_s          = {hi_r[DATA_WIDTH-2:0], lo_r[DATA_WIDTH-1]};
        if (state_r == RUN) begin
            if (is_div_s) begin
                alu_src_a     = sh_s;
                alu_src_b     = opnd_r;
                alu_operation = OPCODE_LENGTH'(ALU_SUB);
            end else begin
                alu_src_a     = hi_r;
                alu_src_b     = lo_r[0] ? opnd_r : '0;
                alu_operation = OPCODE_LENGTH'(ALU_ADD);
            end
        end else begin
            alu_src_a     = '0;
            alu_src_b     = '0;
            alu_operation = '0;
        end
        // hi_r[MSB] set means the shifted remainder overflowed W bits, so it always exceeds the divisor
        carry_s = (alu_result < hi_r);
        ge_s    = hi_r[DATA_WIDTH-1] | (sh_s >= opnd_r);
    end

    // Next-state, datapath update and result capture on entry to DONE
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        opnd_s   = opnd_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    op_s   = muldiv_op_t'(op);
                    opnd_s = op[1] ? operand_b : operand_a;
                    cnt_s  = 6'd0;
                    if (op[1] && (operand_b == '0)) begin
                        hi_s    = operand_a;
                        lo_s    = '1;
                        state_s = DONE;
                    end else if (op[1]) begin
                        hi_s    = '0;
                        lo_s    = operand_a;
                        state_s = RUN;
                    end else begin
                        hi_s    = '0;
                        lo_s    = operand_b;
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (alu_gnt) begin
                    if (is_div_s) begin
                        hi_s = ge_s ? alu_result : sh_s;
                        lo_s = {lo_r[DATA_WIDTH-2:0], ge_s};
                    end else begin
                        hi_s = {carry_s, alu_result[DATA_WIDTH-1:1]};
                        lo_s = {alu_result[0], lo_r[DATA_WIDTH-1:1]};
                    end
                    if (cnt_r == LAST_CNT) begin
                        state_s = DONE;
                    end else begin
                        cnt_s = cnt_r + 6'd1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half
        if (state_s == DONE) begin
            result_s = op_s[0] ? hi_s : lo_s;
        end else begin
            result_s = result_r;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= OP_MUL;
            hi_r     <= '0;
            lo_r     <= '0;
            opnd_r   <= '0;
            cnt_r    <= 6'd0;
            result_r <= '0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            opnd_r   <= opnd_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy, done, alu_req;
    logic         alu_gnt = 1'b0;
    logic [W-1:0] result, alu_src_a, alu_src_b, alu_result;
    logic [3:0]   alu_operation;

    int checks = 0;
    int failures = 0;
    int gnt_pct = 100;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_result = '0;
    logic [1:0]   cur_op = 2'd0;

    muldiv_sequencer #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result),
        .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_operation(alu_operation), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    always_comb begin
        if (alu_operation == ALU_ADD) alu_result = alu_src_a + alu_src_b;
        else if (alu_operation == ALU_SUB) alu_result = alu_src_a - alu_src_b;
        else alu_result = alu_src_a & alu_src_b;
    end

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == '0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Grant generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            alu_gnt = (gnt_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < gnt_pct);
        end
    end

    logic         prev_busy = 1'b0, prev_gnt = 1'b0, prev_done = 1'b0;
    logic [W-1:0] prev_a = '0, prev_b = '0;
    logic [3:0]   prev_opc = 4'd0;

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_done", {63'd0, done}, 64'd0);
            check("rst_result", {32'd0, result}, 64'd0);
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_pulse", {63'd0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    model_result = exp_q.pop_front();
                    check("result", {32'd0, result}, {32'd0, model_result});
                end
            end else begin
                check("result_hold", {32'd0, result}, {32'd0, model_result});
            end
            if (!busy) begin
                check("idle_src_a", {32'd0, alu_src_a}, 64'd0);
                check("idle_src_b", {32'd0, alu_src_b}, 64'd0);
                check("idle_opc", {60'd0, alu_operation}, 64'd0);
            end else begin
                check("run_opc", {60'd0, alu_operation}, {60'd0, (cur_op[1] ? ALU_SUB : ALU_ADD)});
                if (prev_busy && !prev_gnt) begin
                    check("stall_src_a", {32'd0, alu_src_a}, {32'd0, prev_a});
                    check("stall_src_b", {32'd0, alu_src_b}, {32'd0, prev_b});
                    check("stall_opc", {60'd0, alu_operation}, {60'd0, prev_opc});
                end
            end
            prev_busy = busy;
            prev_gnt  = alu_gnt;
            prev_done = done;
            prev_a    = alu_src_a;
            prev_b    = alu_src_b;
            prev_opc  = alu_operation;
        end
    end

    // One operation: latency counted in edges from the start-sampling edge inclusive
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit use_lit, input logic [W-1:0] lit, input int poke);
        int  n, ung, bc;
        bit  div0;
        div0 = o[1] && (b == '0);
        @(posedge clk);
        #1;
        op = o; operand_a = a; operand_b = b; start = 1'b1; cur_op = o;
        exp_q.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
        n = 1; ung = 0; bc = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            check("busy", {63'd0, busy}, {63'd0, !div0});
            check("alu_req", {63'd0, alu_req}, {63'd0, !div0});
            if (busy) bc++;
            if (busy && !alu_gnt) ung++;
            if (n >= 2000) begin
                check("timeout", 64'(n), 64'd0);
                break;
            end
            @(posedge clk);
            n++;
            if (poke >= 0 && n == poke) begin
                #1;
                start = 1'b1; op = ~o; operand_a = 32'h1234_5678; operand_b = 32'd3;
            end else if (poke >= 0 && n == poke + 1) begin
                #1;
                start = 1'b0;
            end
        end
        if (done) begin
            check("latency", 64'(n), div0 ? 64'd1 : 64'(33 + ung));
            check("busy_cycles", 64'(bc), div0 ? 64'd0 : 64'(32 + ung));
            check("busy_at_done", {63'd0, busy}, 64'd0);
            if (use_lit) check("directed_result", {32'd0, result}, {32'd0, lit});
        end
    endtask

    // Abort a MUL with reset while cnt is 10
    task automatic reset_mid();
        @(posedge clk);
        #1;
        op = 2'd0; operand_a = $urandom; operand_b = $urandom; start = 1'b1; cur_op = 2'd0;
        exp_q.push_back(model(2'd0, operand_a, operand_b));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_result = '0;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_result", {32'd0, result}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int           sel;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_pct = 100;
        do_op(2'd0, 32'd7, 32'd6, 1'b1, 32'd42, -1);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, -1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, -1);
        do_op(2'd2, 32'd100, 32'd7, 1'b1, 32'd14, -1);
        do_op(2'd3, 32'd100, 32'd7, 1'b1, 32'd2, -1);
        do_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'd1, -1);
        do_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE, -1);
        do_op(2'd2, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, -1);
        do_op(2'd3, 32'd5, 32'd0, 1'b1, 32'd5, -1);
        do_op(2'd0, 32'd12345, 32'd678, 1'b1, 32'd8369910, 5);
        reset_mid();
        do_op(2'd2, 32'd1000, 32'd3, 1'b1, 32'd333, -1);
        gnt_pct = 50;
        for (int i = 0; i < 1000; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = 32'($urandom_range(1, 15));
            else if (sel == 2) rb = ra;
            else rb = $urandom;
            do_op(ro, ra, rb, 1'b0, '0, -1);
        end
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
